pool2d_stream: RTL and testbench
================================

// Module: pool2d_stream
// PURPOSE
//  Streaming non-overlapping PxP pooler over an MxM signed fixed-point feature map, one pixel/cycle in raster order.
//  Next-generation pooler: runtime max/average mode, valid/ready handshake on both sides, and a widened accumulator.
//  Average mode multiplies by a reciprocal and saturates the result.
//  Sits between a convolution stage and the next layer's input buffer.
// PARAMETERS
//  N          8     data width, signed two's complement
//  Q          4     fractional bits of data and of P_SQR_INV
//  M          12    map width = height; M % P == 0 required
//  P          3     window size = stride
//  P_SQR_INV  8'h02 (1/P^2) in the (N,Q) format; ignored in max mode
// PORTS
//  clk         in   1  clock
//  master_rst  in   1  async active-low reset
//  clr         in   1  sync clear: abort the frame, zero all counters and state
//  mode        in   1  0 = average, 1 = max; sampled on the first accepted pixel of each frame
//  in_valid    in   1  data_in valid
//  in_ready    out  1  pixel accepted when in_valid & in_ready
//  data_in     in   N  input pixel
//  out_valid   out  1  data_out valid
//  out_ready   in   1  downstream accepts
//  data_out    out  N  pooled result
//  end_op      out  1  high with the last output of a frame, while that output is valid
// BEHAVIOUR
//  - Reset (master_rst=0) or clr=1: out_valid=0, data_out=0, end_op=0, row/col counters=0, line buffer cleared.
//  - in_ready = !out_valid | out_ready. The output register is single-entry with no skid.
//  - Counters col, row run 0..M-1 and advance only on an accepted pixel. col wraps to 0 and increments row; row wraps to 0 at frame end.
//  - Line buffer: M/P entries, ACC_W = N + clog2(P*P) bits, indexed by col/P.
//  - Per accepted pixel, let acc = buf[col/P]:
//     - row%P==0 and col%P==0: acc = data_in (sign-extended).
//     - Otherwise, max mode: acc = signed max(acc, data_in). Average mode: acc = acc + data_in.
//  - Window complete when row%P==P-1 and col%P==P-1:
//     - Result is registered into data_out and out_valid=1 on the next cycle (latency 1).
//     - Max mode: data_out = acc[N-1:0].
//     - Avg mode: product = acc*P_SQR_INV (ACC_W+N bits), shifted right arithmetic by Q, saturated to [-2^(N-1), 2^(N-1)-1].
//  - out_valid holds and data_out stays stable until out_ready=1. On an out_ready beat with no new window, out_valid drops.
//  - A new completed window on the same cycle as an out_ready beat reloads data_out back-to-back.
//  - end_op = out_valid for the window at row=M-1, col=M-1. It clears with that beat.
//  - Mode latch: set on the row=0,col=0 accept. A mode change mid-frame has no effect until the next frame.
//  - clr wins over an in-flight accept in the same cycle. A partial frame is discarded and no output is produced for it.
//  - Frames run back-to-back: the first pixel of the next frame may be accepted the cycle after the last pixel of the current frame.
// CONFIGURATION
//  - POOL_RND_EN defined: average mode adds 2^(Q-1) to the product before the >>Q shift (round half up), then saturates.
//  - POOL_RND_EN undefined: truncation toward -inf (plain arithmetic shift). Max mode is unaffected either way.
// TESTING
//  - M=4,P=2,mode=1, data_in 0..15 raster, out_ready=1 -> outputs 5,7,13,15. end_op high with 15.
//  - Same stimulus, mode=0, P_SQR_INV=8'h04, Q=4 -> 2,4,10,12 (truncate). With POOL_RND_EN -> 3,5,11,13.
//  - Max mode, all pixels 8'h80 except one 8'hFF per window -> each output 8'hFF (-1).
//    Avg mode, all pixels 8'h7F -> no wrap, output 8'h7F (no overflow).
//  - Average mode, all pixels 8'h80 -> 8'h80 (saturation floor, no wrap).
//  - Hold out_ready=0 after the first window completes -> in_ready=0, data_out stable 10 cycles.
//    Release -> remaining outputs correct, no loss or duplication.
//  - Assert clr (or master_rst=0) mid-frame at row=1,col=2 -> outputs clear immediately.
//    The next full frame produces the correct results with no stale partial sums.

Source files
------------

// File: rtl/pool2d_stream.sv
// Streaming non-overlapping PxP max/average pooler with valid/ready on both sides.
// Optional macro POOL_RND_EN: round-half-up in average mode instead of truncation.
`default_nettype none

module pool2d_stream #(
  parameter int          N         = 8,
  parameter int          Q         = 4,
  parameter int          M         = 12,
  parameter int          P         = 3,
  parameter logic [N-1:0] P_SQR_INV = 8'h02
) (
  input  logic         clk,
  input  logic         master_rst,
  input  logic         clr,
  input  logic         mode,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] data_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] data_out,
  output logic         end_op
);

  localparam int ACC_W  = N + $clog2(P * P);
  localparam int PROD_W = ACC_W + N + 1;
  localparam int NBLK   = M / P;
  localparam int CW     = (M > 1) ? $clog2(M) : 1;
  localparam int PW     = (P > 1) ? $clog2(P) : 1;
  localparam int BW     = (NBLK > 1) ? $clog2(NBLK) : 1;

  localparam logic [CW-1:0]            LAST_POS = CW'(M - 1);
  localparam logic [PW-1:0]            LAST_PH  = PW'(P - 1);
  localparam logic signed [N-1:0]      INV_S    = P_SQR_INV;
  localparam logic signed [PROD_W-1:0] SAT_HI   = PROD_W'((2 ** (N - 1)) - 1);
  localparam logic signed [PROD_W-1:0] SAT_LO   = ~SAT_HI;
`ifdef POOL_RND_EN
  localparam logic signed [PROD_W-1:0] RND_K    = PROD_W'(2 ** (Q - 1));
`endif

  logic [CW-1:0] col, row;
  logic [PW-1:0] col_ph, row_ph;
  logic [BW-1:0] blk;
  logic          mode_lat;
  logic signed [ACC_W-1:0] line_buf [NBLK];

  logic                    accept, frame_start, frame_last;
  logic                    win_first, win_done, mode_eff;
  logic signed [ACC_W-1:0] acc_old, din_ext, acc_new;
  logic signed [PROD_W-1:0] prod, prod_rnd, scaled;
  logic [N-1:0]            avg_res, win_res;

  assign in_ready    = !out_valid || out_ready;
  assign accept      = in_valid && in_ready;
  assign frame_start = (row == '0) && (col == '0);
  assign frame_last  = (row == LAST_POS) && (col == LAST_POS);
  assign win_first   = (row_ph == '0) && (col_ph == '0);
  assign win_done    = (row_ph == LAST_PH) && (col_ph == LAST_PH);
  // The first pixel of a frame uses the live mode input; the rest use the latch.
  assign mode_eff    = frame_start ? mode : mode_lat;
  assign acc_old     = line_buf[blk];
  assign din_ext     = {{(ACC_W - N){data_in[N-1]}}, data_in};

  always_comb begin
    acc_new = acc_old;
    if (win_first) begin
      acc_new = din_ext;
    end else if (mode_eff) begin
      acc_new = (din_ext > acc_old) ? din_ext : acc_old;
    end else begin
      acc_new = acc_old + din_ext;
    end
  end

  always_comb begin
    prod     = PROD_W'(acc_new) * PROD_W'(INV_S);
`ifdef POOL_RND_EN
    prod_rnd = prod + RND_K;
`else
    prod_rnd = prod;
`endif
    scaled   = prod_rnd >>> Q;
    avg_res  = scaled[N-1:0];
    if (scaled > SAT_HI) begin
      avg_res = SAT_HI[N-1:0];
    end else if (scaled < SAT_LO) begin
      avg_res = SAT_LO[N-1:0];
    end
    win_res = mode_eff ? acc_new[N-1:0] : avg_res;
  end

  // Raster position, window phase and line-buffer column block.
  always_ff @(posedge clk or negedge master_rst) begin
    if (!master_rst) begin
      col      <= '0;
      row      <= '0;
      col_ph   <= '0;
      row_ph   <= '0;
      blk      <= '0;
      mode_lat <= 1'b0;
      for (int i = 0; i < NBLK; i++) line_buf[i] <= '0;
    end else if (clr) begin
      col      <= '0;
      row      <= '0;
      col_ph   <= '0;
      row_ph   <= '0;
      blk      <= '0;
      mode_lat <= 1'b0;
      for (int i = 0; i < NBLK; i++) line_buf[i] <= '0;
    end else if (accept) begin
      line_buf[blk] <= acc_new;
      if (frame_start) mode_lat <= mode;
      if (col_ph == LAST_PH) begin
        col_ph <= '0;
        blk    <= blk + BW'(1);
      end else begin
        col_ph <= col_ph + PW'(1);
      end
      if (col == LAST_POS) begin
        col <= '0;
        blk <= '0;
        if (row == LAST_POS) begin
          row    <= '0;
          row_ph <= '0;
        end else begin
          row    <= row + CW'(1);
          row_ph <= (row_ph == LAST_PH) ? '0 : row_ph + PW'(1);
        end
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // Single-entry output register; a completing window may reload it on a draining beat.
  always_ff @(posedge clk or negedge master_rst) begin
    if (!master_rst) begin
      out_valid <= 1'b0;
      data_out  <= '0;
      end_op    <= 1'b0;
    end else if (clr) begin
      out_valid <= 1'b0;
      data_out  <= '0;
      end_op    <= 1'b0;
    end else if (accept && win_done) begin
      out_valid <= 1'b1;
      data_out  <= win_res;
      end_op    <= frame_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      end_op    <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pool2d_stream.sv
// Randomized self-checking bench for pool2d_stream (M=4, P=2, P_SQR_INV=4) with a window-level reference model.
`default_nettype none

module tb_pool2d_stream;

  localparam int TN   = 8;
  localparam int TQ   = 4;
  localparam int TM   = 4;
  localparam int TP   = 2;
  localparam int TINV = 4;
  localparam int FPIX = TM * TM;

  logic          clk = 1'b0;
  logic          master_rst;
  logic          clr;
  logic          mode;
  logic          in_valid;
  logic          in_ready;
  logic [TN-1:0] data_in;
  logic          out_valid;
  logic          out_ready;
  logic [TN-1:0] data_out;
  logic          end_op;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [7:0] pix_q[$];
  bit         fmode_q[$];
  logic [7:0] exp_q[$];
  bit         end_q[$];

  pool2d_stream #(
    .N(TN), .Q(TQ), .M(TM), .P(TP), .P_SQR_INV(8'h04)
  ) dut (
    .clk(clk), .master_rst(master_rst), .clr(clr), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
    .end_op(end_op)
  );

  always #5 clk = ~clk;

  // Reference: pool each window of the frame starting at pix_q[base] in raster order of completion.
  function automatic void model_frame(input int base, input bit md);
    for (int wr = 0; wr < TM / TP; wr++) begin
      for (int wc = 0; wc < TM / TP; wc++) begin
        int acc;
        int v;
        acc = md ? -1000000 : 0;
        for (int r = 0; r < TP; r++) begin
          for (int c = 0; c < TP; c++) begin
            int px;
            px = int'($signed(pix_q[base + (wr * TP + r) * TM + wc * TP + c]));
            if (md) acc = (px > acc) ? px : acc;
            else    acc = acc + px;
          end
        end
        if (md) begin
          v = acc;
        end else begin
          v = acc * TINV;
`ifdef POOL_RND_EN
          v = v + (1 << (TQ - 1));
`endif
          v = v >>> TQ;
          if (v > 127)  v = 127;
          if (v < -128) v = -128;
        end
        exp_q.push_back(8'(v));
        end_q.push_back((wr == TM / TP - 1) && (wc == TM / TP - 1));
      end
    end
  endfunction

  task automatic clear_queues();
    pix_q.delete();
    fmode_q.delete();
    exp_q.delete();
    end_q.delete();
  endtask

  // Drives pix_q and checks every output beat against exp_q/end_q.
  task automatic run_stream(input string name, input int ready_pct, input int valid_pct, input bit hold_first);
    int pi = 0;
    int oi = 0;
    int cyc = 0;
    bit held = 0;
    while ((oi < exp_q.size()) && (cyc < 3000)) begin
      @(negedge clk);
      cyc++;
      out_ready = ($urandom_range(99) < ready_pct);
      if ((pi < pix_q.size()) && ($urandom_range(99) < valid_pct)) begin
        in_valid = 1'b1;
        data_in  = pix_q[pi];
      end else begin
        in_valid = 1'b0;
        data_in  = 8'($urandom);
      end
      mode = ((pi % FPIX) == 0 && pi < pix_q.size()) ? fmode_q[pi / FPIX] : 1'($urandom);
      #1;
      if (hold_first && !held && out_valid) begin
        held = 1;
        out_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          #1;
          total_cnt++;
          if (in_ready !== 1'b0) $display("FAIL %s hold in_ready cyc%0d: got %b want 0", name, k, in_ready);
          else pass_cnt++;
          total_cnt++;
          if (out_valid !== 1'b1) $display("FAIL %s hold out_valid cyc%0d: got %b want 1", name, k, out_valid);
          else pass_cnt++;
          total_cnt++;
          if (data_out !== exp_q[0]) $display("FAIL %s hold data_out cyc%0d: got %h want %h", name, k, data_out, exp_q[0]);
          else pass_cnt++;
        end
        out_ready = 1'b1;
        #1;
      end
      if (out_valid && out_ready) begin
        total_cnt++;
        if (data_out !== exp_q[oi]) $display("FAIL %s data_out[%0d]: got %h want %h", name, oi, data_out, exp_q[oi]);
        else pass_cnt++;
        total_cnt++;
        if (end_op !== end_q[oi]) $display("FAIL %s end_op[%0d]: got %b want %b", name, oi, end_op, end_q[oi]);
        else pass_cnt++;
        oi++;
      end
      if (in_valid && in_ready) pi++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    total_cnt++;
    if (oi < exp_q.size()) $display("FAIL %s timeout: got %0d outputs want %0d", name, oi, exp_q.size());
    else pass_cnt++;
    @(negedge clk);
    #1;
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL %s extra output: out_valid got %b want 0", name, out_valid);
    else pass_cnt++;
  endtask

  task automatic push_frame(input bit md, input int style);
    int base;
    base = pix_q.size();
    fmode_q.push_back(md);
    for (int i = 0; i < FPIX; i++) begin
      case (style)
        0:       pix_q.push_back(8'($urandom));
        1:       pix_q.push_back(($urandom_range(1) == 1) ? 8'h7F : 8'h80);
        default: pix_q.push_back(8'($urandom_range(15)) - 8'd8);
      endcase
    end
    model_frame(base, md);
  endtask

  task automatic test_reset();
    master_rst = 1'b0;
    clr        = 1'b0;
    mode       = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    data_in    = '0;
    repeat (3) @(negedge clk);
    #1;
    total_cnt++;
    if ({out_valid, end_op, data_out} !== 10'b0) $display("FAIL reset outputs: got v=%b e=%b d=%h want 0", out_valid, end_op, data_out);
    else pass_cnt++;
    master_rst = 1'b1;
    @(negedge clk);
    #1;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL reset in_ready: got %b want 1", in_ready);
    else pass_cnt++;
  endtask

  task automatic test_max_directed();
    clear_queues();
    fmode_q.push_back(1'b1);
    for (int i = 0; i < FPIX; i++) pix_q.push_back(8'(i));
    exp_q = '{8'd5, 8'd7, 8'd13, 8'd15};
    end_q = '{1'b0, 1'b0, 1'b0, 1'b1};
    run_stream("max_ramp", 100, 100, 0);
  endtask

  task automatic test_avg_directed();
    clear_queues();
    fmode_q.push_back(1'b0);
    for (int i = 0; i < FPIX; i++) pix_q.push_back(8'(i));
`ifdef POOL_RND_EN
    exp_q = '{8'd3, 8'd5, 8'd11, 8'd13};
`else
    exp_q = '{8'd2, 8'd4, 8'd10, 8'd12};
`endif
    end_q = '{1'b0, 1'b0, 1'b0, 1'b1};
    run_stream("avg_ramp", 100, 100, 0);
  endtask

  task automatic test_extremes();
    int hot;
    clear_queues();
    fmode_q.push_back(1'b1);
    for (int i = 0; i < FPIX; i++) pix_q.push_back(8'h80);
    for (int w = 0; w < 4; w++) begin
      hot = $urandom_range(3);
      pix_q[((w / 2) * TP + hot / 2) * TM + (w % 2) * TP + hot % 2] = 8'hFF;
    end
    exp_q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    end_q = '{1'b0, 1'b0, 1'b0, 1'b1};
    run_stream("max_neg", 100, 100, 0);

    clear_queues();
    fmode_q.push_back(1'b0);
    for (int i = 0; i < FPIX; i++) pix_q.push_back(8'h7F);
    exp_q = '{8'h7F, 8'h7F, 8'h7F, 8'h7F};
    end_q = '{1'b0, 1'b0, 1'b0, 1'b1};
    run_stream("avg_pos_max", 100, 100, 0);

    clear_queues();
    fmode_q.push_back(1'b0);
    for (int i = 0; i < FPIX; i++) pix_q.push_back(8'h80);
    exp_q = '{8'h80, 8'h80, 8'h80, 8'h80};
    end_q = '{1'b0, 1'b0, 1'b0, 1'b1};
    run_stream("avg_floor", 100, 100, 0);
  endtask

  task automatic test_backpressure();
    clear_queues();
    push_frame(1'b0, 0);
    run_stream("backpressure", 100, 100, 1);
  endtask

  task automatic test_back_to_back();
    clear_queues();
    push_frame(1'b1, 0);
    push_frame(1'b0, 0);
    push_frame(1'b1, 2);
    run_stream("back_to_back", 100, 100, 0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      clear_queues();
      for (int f = 0; f < int'($urandom_range(1, 3)); f++) push_frame(1'($urandom), $urandom_range(2));
      run_stream("random", $urandom_range(30, 100), $urandom_range(30, 100), 0);
    end
  endtask

  // Abort a frame at row=1,col=2 by clr (use_rst=0) or master_rst (use_rst=1), then run a clean frame.
  task automatic test_abort(input bit use_rst);
    string name;
    name = use_rst ? "abort_rst" : "abort_clr";
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      data_in  = 8'(i + 20);
      mode     = 1'b1;
    end
    @(negedge clk);
    data_in = 8'd26;
    #1;
    total_cnt++;
    if ({out_valid, data_out} !== {1'b1, 8'd25}) $display("FAIL %s pre-abort: got v=%b d=%h want v=1 d=19", name, out_valid, data_out);
    else pass_cnt++;
    if (use_rst) begin
      master_rst = 1'b0;
      #1;
    end else begin
      clr = 1'b1;
      @(negedge clk);
      clr      = 1'b0;
      in_valid = 1'b0;
      #1;
    end
    total_cnt++;
    if ({out_valid, end_op, data_out} !== 10'b0) $display("FAIL %s cleared outputs: got v=%b e=%b d=%h want 0", name, out_valid, end_op, data_out);
    else pass_cnt++;
    in_valid = 1'b0;
    @(negedge clk);
    master_rst = 1'b1;
    clear_queues();
    push_frame(1'b0, 0);
    run_stream(name, 100, 100, 0);
  endtask

  initial begin
    test_reset();
    test_max_directed();
    test_avg_directed();
    test_extremes();
    test_backpressure();
    test_back_to_back();
    test_abort(1'b0);
    test_abort(1'b1);
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
